// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS-subset controller sequencing IF/ID/EXE/MA/MR/MW/WB/LWB/BR/JMP
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; forces all outputs to 0 and loads IF
//   opcode     in   IR[31:26], stable from ID onward
//   funct      in   IR[5:0]
//   zero       in   ALU zero flag, sampled in BR
//   OF         in   registered addi overflow flag, sampled in WB
//   dm_ready   in   data-memory ready, honoured only when MEM_WAIT_EN is defined
//   PCWr       out  PC write enable
//   NPCOp      out  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 rs
//   IRWr       out  IR write enable
//   RegDst     out  00 rt, 01 rd, 10 link register
//   ALUSrc     out  0 rt data, 1 extended immediate
//   ExtOp      out  1 sign-extend, 0 zero-extend
//   ALUctr     out  00 add, 01 sub/slt, 10 or, 11 lui
//   MemtoReg   out  00 ALUOut, 01 DR, 10 PC
//   RegWrite   out  GPR write enable
//   MemWrite   out  DM write enable
//   instr_done out  pulse in the final state of every instruction
//   state      out  current state (debug), 0 while reset is high
//
// Build option
//   MEM_WAIT_EN  when defined, MR and MW stall until dm_ready=1; otherwise they last one cycle.
module mc_ctrl_fsm #(
    parameter int ST_W   = 4,
    parameter int RA_IDX = 31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            OF,
    input  logic            dm_ready,
    output logic            PCWr,
    output logic [1:0]      NPCOp,
    output logic            IRWr,
    output logic [1:0]      RegDst,
    output logic            ALUSrc,
    output logic            ExtOp,
    output logic [1:0]      ALUctr,
    output logic [1:0]      MemtoReg,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            instr_done,
    output logic [ST_W-1:0] state
);
    localparam logic [ST_W-1:0] S_IF  = ST_W'(0);
    localparam logic [ST_W-1:0] S_ID  = ST_W'(1);
    localparam logic [ST_W-1:0] S_EXE = ST_W'(2);
    localparam logic [ST_W-1:0] S_MA  = ST_W'(3);
    localparam logic [ST_W-1:0] S_MR  = ST_W'(4);
    localparam logic [ST_W-1:0] S_MW  = ST_W'(5);
    localparam logic [ST_W-1:0] S_WB  = ST_W'(6);
    localparam logic [ST_W-1:0] S_LWB = ST_W'(7);
    localparam logic [ST_W-1:0] S_BR  = ST_W'(8);
    localparam logic [ST_W-1:0] S_JMP = ST_W'(9);

    // The datapath routes RegDst code 2'b10 to register RA_IDX; a legal GPR index keeps that code.
    localparam logic [1:0] DST_RA = (RA_IDX >= 0 && RA_IDX < 32) ? 2'b10 : 2'b00;

    logic [ST_W-1:0] state_q, state_d;
    logic is_r, is_addu, is_subu, is_slt, is_jr;
    logic is_ori, is_lui, is_addi, is_addiu, is_lw, is_sw, is_beq, is_j, is_jal;
    logic is_r_alu, is_i_alu, is_alu, is_mem, is_jump, mem_go;
    logic [1:0] alu_op;

    assign is_r     = opcode == 6'h00;
    assign is_addu  = is_r && funct == 6'h21;
    assign is_subu  = is_r && funct == 6'h23;
    assign is_slt   = is_r && funct == 6'h2A;
    assign is_jr    = is_r && funct == 6'h08;
    assign is_ori   = opcode == 6'h0D;
    assign is_lui   = opcode == 6'h0F;
    assign is_addi  = opcode == 6'h08;
    assign is_addiu = opcode == 6'h09;
    assign is_lw    = opcode == 6'h23;
    assign is_sw    = opcode == 6'h2B;
    assign is_beq   = opcode == 6'h04;
    assign is_j     = opcode == 6'h02;
    assign is_jal   = opcode == 6'h03;

    assign is_r_alu = is_addu || is_subu || is_slt;
    assign is_i_alu = is_ori || is_lui || is_addi || is_addiu;
    assign is_alu   = is_r_alu || is_i_alu;
    assign is_mem   = is_lw || is_sw;
    assign is_jump  = is_j || is_jal || is_jr;

    assign alu_op = (is_subu || is_slt) ? 2'b01 :
                    is_ori              ? 2'b10 :
                    is_lui              ? 2'b11 : 2'b00;

`ifdef MEM_WAIT_EN
    assign mem_go = dm_ready;
`else
    logic unused_dm_ready;
    assign unused_dm_ready = dm_ready;
    assign mem_go          = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IF;
        else
            state_q <= state_d;
    end

    // WB, LWB, BR, JMP and the unused codes all return to IF.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID:    state_d = is_alu  ? S_EXE :
                               is_mem  ? S_MA  :
                               is_beq  ? S_BR  :
                               is_jump ? S_JMP : S_IF;
            S_EXE:   state_d = S_WB;
            S_MA:    state_d = is_lw ? S_MR : S_MW;
            S_MR:    state_d = mem_go ? S_LWB : S_MR;
            S_MW:    state_d = mem_go ? S_IF : S_MW;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        PCWr       = 1'b0;
        NPCOp      = 2'b00;
        IRWr       = 1'b0;
        RegDst     = 2'b00;
        ALUSrc     = 1'b0;
        ExtOp      = 1'b0;
        ALUctr     = 2'b00;
        MemtoReg   = 2'b00;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        instr_done = 1'b0;
        state      = reset ? S_IF : state_q;
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    IRWr = 1'b1;
                    PCWr = 1'b1;
                end
                // Unrecognised encodings retire here as a nop; PC already advanced in IF.
                S_ID:  instr_done = !(is_alu || is_mem || is_beq || is_jump);
                S_EXE: begin
                    ALUSrc = is_i_alu;
                    ExtOp  = is_addi || is_addiu;
                    ALUctr = alu_op;
                end
                S_WB: begin
                    RegWrite   = is_addi ? !OF : 1'b1;
                    RegDst     = is_r_alu ? 2'b01 : 2'b00;
                    instr_done = 1'b1;
                end
                S_MA: begin
                    ALUSrc = 1'b1;
                    ExtOp  = 1'b1;
                end
                S_LWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 2'b01;
                    instr_done = 1'b1;
                end
                S_MW: begin
                    MemWrite   = 1'b1;
                    instr_done = mem_go;
                end
                S_BR: begin
                    ALUctr     = 2'b01;
                    PCWr       = zero;
                    NPCOp      = 2'b01;
                    instr_done = 1'b1;
                end
                S_JMP: begin
                    PCWr       = 1'b1;
                    NPCOp      = is_jr ? 2'b11 : 2'b10;
                    RegWrite   = is_jal;
                    RegDst     = is_jal ? DST_RA : 2'b00;
                    MemtoReg   = is_jal ? 2'b10 : 2'b00;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven cycle-by-cycle check of mc_ctrl_fsm outputs
module tb_mc_ctrl_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] opcode = 6'h0;
    logic [5:0] funct = 6'h0;
    logic zero = 1'b0;
    logic OF = 1'b0;
    logic dm_ready = 1'b1;
    logic PCWr, IRWr, ALUSrc, ExtOp, RegWrite, MemWrite, instr_done;
    logic [1:0] NPCOp, RegDst, ALUctr, MemtoReg;
    logic [3:0] state;
    logic [18:0] got;
    logic [18:0] e_if, e_id, e_zero;
    int total = 0;
    int bad = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        of;
        logic        dm;
        logic [18:0] exp;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .OF(OF),
        .dm_ready(dm_ready), .PCWr(PCWr), .NPCOp(NPCOp), .IRWr(IRWr), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUctr(ALUctr), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .instr_done(instr_done), .state(state)
    );

    assign got = {PCWr, NPCOp, IRWr, RegDst, ALUSrc, ExtOp, ALUctr, MemtoReg,
                  RegWrite, MemWrite, instr_done, state};

    function automatic logic [18:0] o(input logic pcwr, input logic [1:0] npc, input logic irwr,
                                      input logic [1:0] rd, input logic als, input logic ext,
                                      input logic [1:0] alu, input logic [1:0] m2r,
                                      input logic rw, input logic mw, input logic dn,
                                      input logic [3:0] st);
        return {pcwr, npc, irwr, rd, als, ext, alu, m2r, rw, mw, dn, st};
    endfunction

    task automatic add(input string nm, input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic of, input logic dm, input logic [18:0] e);
        vec_t v;
        v.name = nm; v.rst = r; v.op = op; v.fn = fn; v.z = z; v.of = of; v.dm = dm; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic step(input string nm, input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic of, input logic dm, input logic [18:0] e);
        @(posedge clk);
        #1;
        reset = r; opcode = op; funct = fn; zero = z; OF = of; dm_ready = dm;
        @(negedge clk);
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b", nm, got, e);
        end
    endtask

    task automatic alu_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic of, input logic [18:0] e_exe, input logic [18:0] e_wb);
        add({nm, "_if"}, 0, op, fn, 0, 0, 1, e_if);
        add({nm, "_id"}, 0, op, fn, 0, 0, 1, e_id);
        add({nm, "_exe"}, 0, op, fn, 0, 0, 1, e_exe);
        add({nm, "_wb"}, 0, op, fn, 0, of, 1, e_wb);
    endtask

    initial begin
        logic [18:0] e_rwb, e_iwb, e_ma, e_mr, e_lwb, e_mw;
        e_if   = o(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_id   = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        e_zero = '0;
        e_rwb  = o(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 6);
        e_iwb  = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6);
        e_ma   = o(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3);
        e_mr   = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        e_lwb  = o(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 7);
        e_mw   = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5);

        for (int i = 0; i < 3; i++) add("reset", 1, 6'h23, 6'h00, 1, 1, 1, e_zero);
        alu_instr("addu", 6'h00, 6'h21, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), e_rwb);
        alu_instr("subu", 6'h00, 6'h23, 0, o(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2), e_rwb);
        alu_instr("slt", 6'h00, 6'h2A, 0, o(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2), e_rwb);
        alu_instr("ori", 6'h0D, 6'h00, 0, o(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 2), e_iwb);
        alu_instr("lui", 6'h0F, 6'h00, 0, o(0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 2), e_iwb);
        alu_instr("addi_of", 6'h08, 6'h08, 1, o(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2),
                  o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6));
        alu_instr("addi", 6'h08, 6'h00, 0, o(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2), e_iwb);
        alu_instr("addiu_of", 6'h09, 6'h00, 1, o(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2), e_iwb);
        add("lw_if", 0, 6'h23, 0, 0, 0, 1, e_if);
        add("lw_id", 0, 6'h23, 0, 0, 0, 1, e_id);
        add("lw_ma", 0, 6'h23, 0, 0, 0, 1, e_ma);
        add("lw_mr", 0, 6'h23, 0, 0, 0, 1, e_mr);
        add("lw_lwb", 0, 6'h23, 0, 0, 0, 1, e_lwb);
        add("sw_if", 0, 6'h2B, 0, 0, 0, 1, e_if);
        add("sw_id", 0, 6'h2B, 0, 0, 0, 1, e_id);
        add("sw_ma", 0, 6'h2B, 0, 0, 0, 1, e_ma);
        add("sw_mw", 0, 6'h2B, 0, 0, 0, 1, e_mw);
        add("beq1_if", 0, 6'h04, 0, 1, 0, 1, e_if);
        add("beq1_id", 0, 6'h04, 0, 1, 0, 1, e_id);
        add("beq1_br", 0, 6'h04, 0, 1, 0, 1, o(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8));
        add("beq0_if", 0, 6'h04, 0, 0, 0, 1, e_if);
        add("beq0_id", 0, 6'h04, 0, 0, 0, 1, e_id);
        add("beq0_br", 0, 6'h04, 0, 0, 0, 1, o(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8));
        add("j_if", 0, 6'h02, 0, 0, 0, 1, e_if);
        add("j_id", 0, 6'h02, 0, 0, 0, 1, e_id);
        add("j_jmp", 0, 6'h02, 0, 0, 0, 1, o(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9));
        add("jal_if", 0, 6'h03, 6'h08, 0, 0, 1, e_if);
        add("jal_id", 0, 6'h03, 6'h08, 0, 0, 1, e_id);
        add("jal_jmp", 0, 6'h03, 6'h08, 0, 0, 1, o(1, 2, 0, 2, 0, 0, 0, 2, 1, 0, 1, 9));
        add("jr_if", 0, 6'h00, 6'h08, 0, 0, 1, e_if);
        add("jr_id", 0, 6'h00, 6'h08, 0, 0, 1, e_id);
        add("jr_jmp", 0, 6'h00, 6'h08, 0, 0, 1, o(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9));
        add("ill_if", 0, 6'h3F, 0, 0, 0, 1, e_if);
        add("ill_id", 0, 6'h3F, 0, 0, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        add("badfn_if", 0, 6'h00, 6'h20, 0, 0, 1, e_if);
        add("badfn_id", 0, 6'h00, 6'h20, 0, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        add("rlw_if", 0, 6'h23, 0, 0, 0, 1, e_if);
        add("rlw_id", 0, 6'h23, 0, 0, 0, 1, e_id);
        add("rlw_ma", 0, 6'h23, 0, 0, 0, 1, e_ma);
        add("rlw_mr_rst", 1, 6'h23, 0, 0, 0, 1, e_zero);
        add("rlw_after", 0, 6'h23, 0, 0, 0, 1, e_if);
        add("rlw_id2", 0, 6'h23, 0, 0, 0, 1, e_id);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].name, tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].of, tbl[i].dm,
                 tbl[i].exp);

        // restart cleanly, then exercise dm_ready=0 in MW and MR
        step("re_rst", 1, 6'h2B, 0, 0, 0, 1, e_zero);
        step("ws_if", 0, 6'h2B, 0, 0, 0, 1, e_if);
        step("ws_id", 0, 6'h2B, 0, 0, 0, 1, e_id);
        step("ws_ma", 0, 6'h2B, 0, 0, 0, 1, e_ma);
`ifdef MEM_WAIT_EN
        for (int i = 0; i < 3; i++) step("ws_mw_hold", 0, 6'h2B, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5));
        step("ws_mw_go", 0, 6'h2B, 0, 0, 0, 1, e_mw);
        step("wl_if", 0, 6'h23, 0, 0, 0, 0, e_if);
        step("wl_id", 0, 6'h23, 0, 0, 0, 0, e_id);
        step("wl_ma", 0, 6'h23, 0, 0, 0, 0, e_ma);
        step("wl_mr_hold", 0, 6'h23, 0, 0, 0, 0, e_mr);
        step("wl_mr_hold", 0, 6'h23, 0, 0, 0, 0, e_mr);
        step("wl_mr_go", 0, 6'h23, 0, 0, 0, 1, e_mr);
        step("wl_lwb", 0, 6'h23, 0, 0, 0, 0, e_lwb);
        step("wr_if", 0, 6'h2B, 0, 0, 0, 0, e_if);
        step("wr_id", 0, 6'h2B, 0, 0, 0, 0, e_id);
        step("wr_ma", 0, 6'h2B, 0, 0, 0, 0, e_ma);
        step("wr_mw_hold", 0, 6'h2B, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5));
        step("wr_mw_rst", 1, 6'h2B, 0, 0, 0, 0, e_zero);
        step("wr_after", 0, 6'h2B, 0, 0, 0, 0, e_if);
`else
        step("ws_mw_nowait", 0, 6'h2B, 0, 0, 0, 0, e_mw);
        step("wl_if", 0, 6'h23, 0, 0, 0, 0, e_if);
        step("wl_id", 0, 6'h23, 0, 0, 0, 0, e_id);
        step("wl_ma", 0, 6'h23, 0, 0, 0, 0, e_ma);
        step("wl_mr_nowait", 0, 6'h23, 0, 0, 0, 0, e_mr);
        step("wl_lwb", 0, 6'h23, 0, 0, 0, 0, e_lwb);
        step("wl_next_if", 0, 6'h23, 0, 0, 0, 0, e_if);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
